// File: rtl/pe_column_sequencer_if.sv
// Command, weight-write and B-stream signals of one column sequencer.
interface pe_column_sequencer_if #(
  parameter int NB  = 27,
  parameter int NID = 7
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic           cmd_int;
  logic [15:0]    cmd_len;
  logic [NB-2:0]  cmd_bias;
  logic           wr_en;
  logic [NID-1:0] wr_addr;
  logic [7:0]     wr_data;
  logic [NB-1:0]  b_out;
  logic           busy;
  logic           done;

  modport master (
    output cmd_valid, cmd_op, cmd_int, cmd_len, cmd_bias, wr_en, wr_addr, wr_data,
    input  cmd_ready, b_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_int, cmd_len, cmd_bias, wr_en, wr_addr, wr_data,
    output cmd_ready, b_out, busy, done
  );
endinterface

// File: rtl/pe_column_sequencer.sv
// Turns host commands into the B-stream of one PE column and holds its weight buffer.
module pe_column_sequencer #(
  parameter int NB   = 27,
  parameter int NID  = 7,
  parameter int ROWS = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  pe_column_sequencer_if.slave bus
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [15:0] ROWS_LAST = 16'(ROWS - 1);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;

  localparam logic [2:0] C_RSET = 3'd1;
  localparam logic [2:0] C_ALT2 = 3'd2;
  localparam logic [2:0] C_INTM = 3'd3;
  localparam logic [2:0] C_LOAD = 3'd4;
  localparam logic [2:0] C_MULT = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_LDCMD, S_LDW, S_MODE, S_MCMD, S_BIAS, S_END, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          int_q, int_d;
  logic [15:0]   len_q, len_d;
  logic [NB-2:0] bias_q, bias_d;
  logic [NB-1:0] b_out_q, b_out_d;
  logic          done_q, done_d;
  logic [7:0]    buf_q [ROWS];
  logic [7:0]    buf_d [ROWS];
  logic          wr_hit;

  function automatic logic [NB-1:0] ctrl_word(input logic [2:0] code);
    logic [NB-1:0] w;
    w         = '0;
    w[NB-1]   = 1'b1;
    w[10:8]   = code;
    return w;
  endfunction

  function automatic logic [NB-1:0] weight_word(input logic [NID-1:0] row, input logic [7:0] wt);
    logic [NB-1:0] w;
    w            = '0;
    w[NB-1]      = 1'b1;
    w[NID+10:11] = row;
    w[7:0]       = wt;
    return w;
  endfunction

  assign wr_hit = (state_q == S_IDLE) && bus.wr_en && (32'(bus.wr_addr) < ROWS);

  // b_out is built from the next state so the word is registered with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    int_d   = int_q;
    len_d   = len_q;
    bias_d  = bias_q;
    done_d  = 1'b0;
    b_out_d = '0;
    buf_d   = buf_q;

    if (wr_hit) begin
      buf_d[bus.wr_addr[AW-1:0]] = bus.wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          int_d  = bus.cmd_int;
          len_d  = bus.cmd_len;
          bias_d = bus.cmd_bias;
          case (bus.cmd_op)
            OP_RESET: state_d = S_RST;
            OP_LOAD:  state_d = S_LDCMD;
            OP_RUN:   state_d = S_MODE;
            default:  done_d  = 1'b1;
          endcase
        end
      end
      S_RST: begin
        state_d = S_DRAIN;
        cnt_d   = ROWS_LAST;
      end
      S_LDCMD: begin
        state_d = S_LDW;
        cnt_d   = ROWS_LAST;
      end
      S_LDW: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DRAIN;
          cnt_d   = ROWS_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_MODE: state_d = S_MCMD;
      S_MCMD: begin
        if (len_q == 16'd0) begin
          state_d = S_END;
        end else begin
          state_d = S_BIAS;
          cnt_d   = len_q - 16'd1;
        end
      end
      S_BIAS: begin
        if (cnt_q == 16'd0) begin
          state_d = S_END;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_END: begin
        state_d = S_DRAIN;
        cnt_d   = ROWS_LAST;
      end
      S_DRAIN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Weights are read from buf_q: a write in the LOAD accept cycle is already in buf_q by the first weight word.
    case (state_d)
      S_RST:   b_out_d = ctrl_word(C_RSET);
      S_LDCMD: b_out_d = ctrl_word(C_LOAD);
      S_LDW:   b_out_d = weight_word(cnt_d[NID-1:0], buf_q[cnt_d[AW-1:0]]);
      S_MODE:  b_out_d = ctrl_word(int_d ? C_INTM : C_ALT2);
      S_MCMD:  b_out_d = ctrl_word(C_MULT);
      S_BIAS:  b_out_d = {1'b0, bias_d};
      S_END:   b_out_d = ctrl_word(C_ALT2);
      default: b_out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
      len_q   <= '0;
      bias_q  <= '0;
      b_out_q <= '0;
      done_q  <= 1'b0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
      len_q   <= len_d;
      bias_q  <= bias_d;
      b_out_q <= b_out_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.b_out     = b_out_q;

endmodule
